// File: rtl/line_frontend_if.sv
// Word delivery bus between the line front end (master) and the correlator core (slave).
interface line_frontend_if #(
    parameter int DW = 4
) ();
    logic [DW-1:0] data_out;
    logic          data_valid;
    logic          data_ready;

    modport master (output data_out, output data_valid, input data_ready);
    modport slave  (input data_out, input data_valid, output data_ready);
endinterface

// File: rtl/line_frontend.sv
// Board-side front end: line synchroniser, strobe sampler/word packer and one-hot mux scanner.
// Optional PRBS test source is built when LINE_FRONTEND_PRBS_EN is defined.
module line_frontend #(
    parameter int NUM_LINES   = 4,
    parameter int MUX_LINES   = 8,
    parameter int WORD_WIDTH  = 1,
    parameter int SYNC_STAGES = 2,
    parameter int DWELL_WIDTH = 16
) (
    input  logic                   sysclk,
    input  logic                   reset_n,
    input  logic                   enable,
    input  logic                   smp_strobe,
    input  logic [NUM_LINES-1:0]   line_in,
    line_frontend_if.master        bus,
    output logic                   overflow,
    input  logic                   overflow_clr,
    input  logic                   mux_run,
    input  logic [DWELL_WIDTH-1:0] dwell,
    output logic [MUX_LINES-1:0]   mux_out,
    output logic                   scan_wrap,
    input  logic                   prbs_sel
);
    localparam int DATA_W = NUM_LINES * WORD_WIDTH;
    localparam int CNT_W  = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
    localparam int IDX_W  = $clog2(MUX_LINES);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_WIDTH - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MUX_LINES - 1);

    logic [NUM_LINES-1:0]  sync_q [SYNC_STAGES];
    logic [NUM_LINES-1:0]  sync_d [SYNC_STAGES];
    logic [NUM_LINES-1:0]  smp_bits;
    logic [WORD_WIDTH-1:0] shreg_q [NUM_LINES];
    logic [WORD_WIDTH-1:0] shreg_d [NUM_LINES];
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0]     data_q, data_d, word;
    logic                  valid_q, valid_d;
    logic                  ovf_q, ovf_d;
    logic                  sample, complete;

    // Synchroniser chain: stage 0 takes the raw pins
    always_comb begin
        sync_d[0] = line_in;
        for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
    end

`ifdef LINE_FRONTEND_PRBS_EN
    logic [6:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = sample ? {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]} : lfsr_q;
        for (int k = 0; k < NUM_LINES; k++)
            smp_bits[k] = prbs_sel ? lfsr_q[k % 7] : sync_q[SYNC_STAGES-1][k];
    end

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) lfsr_q <= 7'h7F;
        else          lfsr_q <= lfsr_d;
    end
`else
    wire prbs_sel_unused = prbs_sel;
    assign smp_bits = sync_q[SYNC_STAGES-1];
`endif

    // Sampler, packer and word handshake
    always_comb begin
        sample    = enable & smp_strobe;
        complete  = sample && (bit_cnt_q == LAST_BIT);
        bit_cnt_d = bit_cnt_q;
        data_d    = data_q;
        valid_d   = valid_q;
        ovf_d     = ovf_q;
        word      = '0;
        for (int k = 0; k < NUM_LINES; k++) shreg_d[k] = shreg_q[k];

        if (!enable) begin
            bit_cnt_d = '0;
            for (int k = 0; k < NUM_LINES; k++) shreg_d[k] = '0;
        end else if (sample) begin
            bit_cnt_d = complete ? '0 : bit_cnt_q + 1'b1;
            for (int k = 0; k < NUM_LINES; k++)
                shreg_d[k] = (shreg_q[k] << 1) | WORD_WIDTH'(smp_bits[k]);
        end

        for (int k = 0; k < NUM_LINES; k++) word[k*WORD_WIDTH +: WORD_WIDTH] = shreg_d[k];

        if (complete) begin
            data_d  = word;
            valid_d = 1'b1;
        end else if (valid_q && bus.data_ready) begin
            valid_d = 1'b0;
        end

        // A set on the same edge as a clear must win
        if (complete && valid_q && !bus.data_ready) ovf_d = 1'b1;
        else if (overflow_clr)                       ovf_d = 1'b0;
    end

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            for (int k = 0; k < NUM_LINES; k++) shreg_q[k] <= '0;
            bit_cnt_q <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= sync_d[i];
            for (int k = 0; k < NUM_LINES; k++) shreg_q[k] <= shreg_d[k];
            bit_cnt_q <= bit_cnt_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ovf_q     <= ovf_d;
        end
    end

    assign bus.data_out   = data_q;
    assign bus.data_valid = valid_q;
    assign overflow       = ovf_q;

    typedef enum logic {IDLE, SCAN} scan_state_t;

    scan_state_t            state_q;
    logic [IDX_W-1:0]       idx_q;
    logic [DWELL_WIDTH-1:0] dwell_cnt_q;
    logic [MUX_LINES-1:0]   mux_out_q;
    logic                   scan_wrap_q;

    // Scanner: selector and wrap pulse are registered alongside the index
    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            dwell_cnt_q <= '0;
            mux_out_q   <= '0;
            scan_wrap_q <= 1'b0;
        end else begin
            scan_wrap_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    idx_q       <= '0;
                    dwell_cnt_q <= '0;
                    mux_out_q   <= '0;
                    if (mux_run) begin
                        state_q   <= SCAN;
                        mux_out_q <= MUX_LINES'(1);
                    end
                end
                SCAN: begin
                    if (!mux_run) begin
                        state_q     <= IDLE;
                        idx_q       <= '0;
                        dwell_cnt_q <= '0;
                        mux_out_q   <= '0;
                    end else if (dwell_cnt_q == dwell) begin
                        dwell_cnt_q <= '0;
                        if (idx_q == LAST_IDX) begin
                            idx_q       <= '0;
                            mux_out_q   <= MUX_LINES'(1);
                            scan_wrap_q <= 1'b1;
                        end else begin
                            idx_q     <= idx_q + 1'b1;
                            mux_out_q <= MUX_LINES'(1) << (idx_q + 1'b1);
                        end
                    end else begin
                        dwell_cnt_q <= dwell_cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mux_out   = mux_out_q;
    assign scan_wrap = scan_wrap_q;
endmodule

// File: tb/tb_line_frontend.sv
// Bench for line_frontend: a WORD_WIDTH=1 and a WORD_WIDTH=4 instance on a shared clock/reset.
module tb_line_frontend;
    localparam int SYNC = 2;

    logic sysclk = 1'b0;
    logic reset_n;
    always #5 sysclk = ~sysclk;

    int n_checks = 0;
    int n_fail   = 0;

    // Instance 1: four lines, one sample per word
    logic        en1, stb1, clr1, run1, psel1, ovf1, wrap1;
    logic [3:0]  line1;
    logic [15:0] dwell1;
    logic [7:0]  mux1;
    line_frontend_if #(.DW(4)) bus1 ();

    line_frontend #(.NUM_LINES(4), .MUX_LINES(8), .WORD_WIDTH(1), .SYNC_STAGES(SYNC),
                    .DWELL_WIDTH(16)) dut1 (
        .sysclk(sysclk), .reset_n(reset_n), .enable(en1), .smp_strobe(stb1),
        .line_in(line1), .bus(bus1), .overflow(ovf1), .overflow_clr(clr1),
        .mux_run(run1), .dwell(dwell1), .mux_out(mux1), .scan_wrap(wrap1),
        .prbs_sel(psel1));

    // Instance 4: four lines, four samples per word
    logic        en4, stb4, clr4, run4, psel4, ovf4, wrap4;
    logic [3:0]  line4;
    logic [15:0] dwell4;
    logic [7:0]  mux4;
    line_frontend_if #(.DW(16)) bus4 ();

    line_frontend #(.NUM_LINES(4), .MUX_LINES(8), .WORD_WIDTH(4), .SYNC_STAGES(SYNC),
                    .DWELL_WIDTH(16)) dut4 (
        .sysclk(sysclk), .reset_n(reset_n), .enable(en4), .smp_strobe(stb4),
        .line_in(line4), .bus(bus4), .overflow(ovf4), .overflow_clr(clr4),
        .mux_run(run4), .dwell(dwell4), .mux_out(mux4), .scan_wrap(wrap4),
        .prbs_sel(psel4));

    typedef struct {
        logic [3:0] lines;
        logic [3:0] exp_data;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    task automatic strobe1(input logic [3:0] v);
        line1 = v;
        repeat (SYNC + 1) tick();
        stb1 = 1'b1;
        tick();
        stb1 = 1'b0;
    endtask

    task automatic strobe4(input logic b);
        line4 = {4{b}};
        repeat (SYNC + 1) tick();
        stb4 = 1'b1;
        tick();
        stb4 = 1'b0;
    endtask

    task automatic consume4();
        bus4.data_ready = 1'b1;
        tick();
        bus4.data_ready = 1'b0;
    endtask

    // Reference model state for the randomized phase
    logic [3:0]  hist[$];
    logic [3:0]  m_bits[$];
    logic [15:0] m_data, m_word;
    logic        m_valid, m_ovf, m_complete, m_set;

    initial begin
        vec_t vecs[6];
        vecs = '{'{4'b1010, 4'b1010}, '{4'b0101, 4'b0101}, '{4'b1111, 4'b1111},
                 '{4'b0000, 4'b0000}, '{4'b1000, 4'b1000}, '{4'b0011, 4'b0011}};

        reset_n = 1'b0;
        {en1, stb1, clr1, run1, psel1} = '0;
        {en4, stb4, clr4, run4, psel4} = '0;
        line1 = '0; line4 = '0; dwell1 = '0; dwell4 = '0;
        bus1.data_ready = 1'b0;
        bus4.data_ready = 1'b0;
        repeat (3) tick();

        check("rst_data1", bus1.data_out, 4'h0);
        check("rst_valid1", bus1.data_valid, 1'b0);
        check("rst_data4", bus4.data_out, 16'h0);
        check("rst_valid4", bus4.data_valid, 1'b0);
        check("rst_ovf4", ovf4, 1'b0);
        check("rst_mux4", mux4, 8'h00);
        check("rst_wrap4", wrap4, 1'b0);

        reset_n = 1'b1;
        tick();
        en1 = 1'b1;
        en4 = 1'b1;

        // Single-sample words: valid exactly one cycle after the strobe
        for (int i = 0; i < 6; i++) begin
            line1 = vecs[i].lines;
            repeat (5) tick();
            check("vec_valid_before", bus1.data_valid, 1'b0);
            stb1 = 1'b1;
            tick();
            stb1 = 1'b0;
            check("vec_data", bus1.data_out, vecs[i].exp_data);
            check("vec_valid", bus1.data_valid, 1'b1);
            bus1.data_ready = 1'b1;
            tick();
            bus1.data_ready = 1'b0;
            check("vec_consumed", bus1.data_valid, 1'b0);
        end

        // Overflow set, clear, no-set on transfer, set beats clear
        strobe1(4'h3);
        check("ovf_first_valid", bus1.data_valid, 1'b1);
        check("ovf_first_flag", ovf1, 1'b0);
        strobe1(4'hC);
        check("ovf_second_data", bus1.data_out, 4'hC);
        check("ovf_second_flag", ovf1, 1'b1);
        clr1 = 1'b1;
        tick();
        clr1 = 1'b0;
        check("ovf_cleared", ovf1, 1'b0);
        check("ovf_cleared_valid", bus1.data_valid, 1'b1);
        line1 = 4'h5;
        repeat (SYNC + 1) tick();
        stb1 = 1'b1;
        bus1.data_ready = 1'b1;
        tick();
        stb1 = 1'b0;
        bus1.data_ready = 1'b0;
        check("xfer_data", bus1.data_out, 4'h5);
        check("xfer_valid", bus1.data_valid, 1'b1);
        check("xfer_ovf", ovf1, 1'b0);
        line1 = 4'h6;
        repeat (SYNC + 1) tick();
        stb1 = 1'b1;
        clr1 = 1'b1;
        tick();
        stb1 = 1'b0;
        clr1 = 1'b0;
        check("set_wins_ovf", ovf1, 1'b1);
        check("set_wins_data", bus1.data_out, 4'h6);
        clr1 = 1'b1;
        bus1.data_ready = 1'b1;
        tick();
        clr1 = 1'b0;
        bus1.data_ready = 1'b0;
        check("final_clear_ovf", ovf1, 1'b0);
        check("final_clear_valid", bus1.data_valid, 1'b0);

        // Four-sample word 1,0,1,1 on every line
        strobe4(1'b1);
        strobe4(1'b0);
        strobe4(1'b1);
        check("w4_not_yet", bus4.data_valid, 1'b0);
        strobe4(1'b1);
        check("w4_valid", bus4.data_valid, 1'b1);
        check("w4_data", bus4.data_out, 16'hBBBB);
        consume4();

        // enable drop discards the partial word
        strobe4(1'b1);
        strobe4(1'b1);
        en4 = 1'b0;
        tick();
        en4 = 1'b1;
        strobe4(1'b0);
        strobe4(1'b1);
        strobe4(1'b0);
        check("discard_not_yet", bus4.data_valid, 1'b0);
        strobe4(1'b0);
        check("discard_valid", bus4.data_valid, 1'b1);
        check("discard_data", bus4.data_out, 16'h4444);
        en4 = 1'b0;
        tick();
        en4 = 1'b1;
        check("en_low_keeps_valid", bus4.data_valid, 1'b1);
        check("en_low_keeps_data", bus4.data_out, 16'h4444);
        consume4();

        // Scanner, dwell=2: three cycles per position, wrap back to 0x01
        dwell4 = 16'd2;
        run4 = 1'b1;
        tick();
        for (int i = 0; i < 27; i++) begin
            check("scan_mux", mux4, 8'(1) << ((i / 3) % 8));
            check("scan_wrap", wrap4, (i == 24));
            tick();
        end
        run4 = 1'b0;
        tick();
        check("scan_stop_mux", mux4, 8'h00);
        check("scan_stop_wrap", wrap4, 1'b0);

        // Scanner, dwell=0: advance every cycle
        dwell1 = 16'd0;
        run1 = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) begin
            check("dwell0_mux", mux1, 8'(1) << (i % 8));
            check("dwell0_wrap", wrap1, (i == 8));
            tick();
        end
        run1 = 1'b0;
        tick();
        check("dwell0_stop", mux1, 8'h00);

        // Asynchronous reset mid-scan and mid-word
        strobe1(4'hF);
        dwell4 = 16'd5;
        run4 = 1'b1;
        repeat (4) tick();
        strobe4(1'b1);
        strobe4(1'b1);
        check("pre_rst_mux_active", (mux4 != 8'h00), 1'b1);
        @(negedge sysclk);
        reset_n = 1'b0;
        #1;
        check("async_rst_mux", mux4, 8'h00);
        check("async_rst_data1", bus1.data_out, 4'h0);
        check("async_rst_valid1", bus1.data_valid, 1'b0);
        check("async_rst_data4", bus4.data_out, 16'h0);
        run4 = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        strobe4(1'b0);
        strobe4(1'b1);
        strobe4(1'b1);
        check("post_rst_not_yet", bus4.data_valid, 1'b0);
        strobe4(1'b0);
        check("post_rst_data", bus4.data_out, 16'h6666);
        consume4();

`ifdef LINE_FRONTEND_PRBS_EN
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        psel1 = 1'b1;
        line1 = 4'h0;
        tick();
        stb1 = 1'b1;
        tick();
        stb1 = 1'b0;
        psel1 = 1'b0;
        check("prbs_first_word", bus1.data_out, 4'hF);
        bus1.data_ready = 1'b1;
        tick();
        bus1.data_ready = 1'b0;
`endif

        // Randomized run against the reference model
        line4 = 4'h0;
        reset_n = 1'b0;
        repeat (SYNC + 1) tick();
        reset_n = 1'b1;
        tick();
        hist.delete();
        for (int i = 0; i < SYNC; i++) hist.push_back(4'h0);
        m_bits.delete();
        m_data = '0;
        m_valid = 1'b0;
        m_ovf = 1'b0;
        for (int c = 0; c < 800; c++) begin
            logic       e, s, r, cl;
            logic [3:0] l, smp;
            e  = ($urandom_range(0, 15) != 0);
            s  = $urandom_range(0, 1) != 0;
            r  = ($urandom_range(0, 3) == 0);
            cl = ($urandom_range(0, 9) == 0);
            l  = 4'($urandom_range(0, 15));
            en4 = e; stb4 = s; bus4.data_ready = r; clr4 = cl; line4 = l;

            hist.push_back(l);
            smp = hist[hist.size() - 1 - SYNC];
            m_complete = 1'b0;
            m_word = '0;
            if (!e) begin
                m_bits.delete();
            end else if (s) begin
                m_bits.push_back(smp);
                if (m_bits.size() == 4) begin
                    m_complete = 1'b1;
                    for (int k = 0; k < 4; k++)
                        for (int j = 0; j < 4; j++)
                            m_word[k*4 + (3 - j)] = m_bits[j][k];
                    m_bits.delete();
                end
            end
            m_set = m_complete && m_valid && !r;
            if (m_complete) begin
                m_data = m_word;
                m_valid = 1'b1;
            end else if (m_valid && r) begin
                m_valid = 1'b0;
            end
            if (m_set)   m_ovf = 1'b1;
            else if (cl) m_ovf = 1'b0;

            tick();
            check("rnd_data", bus4.data_out, m_data);
            check("rnd_valid", bus4.data_valid, m_valid);
            check("rnd_ovf", ovf4, m_ovf);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/line_frontend.md
Name: line_frontend

Overview:
- Parametrised board-side front end that sits between the board pin mapping and the correlator core.
- Synchronises NUM_LINES raw line inputs and samples them on the sampling strobe.
- Packs WORD_WIDTH samples per line into one word and delivers it to the core over a valid/ready handshake.
- Drives the MUX_LINES selector outputs with a programmable-dwell one-hot scanner, replacing fixed pin wiring with a generalised, sequenced interface.

Parameters:
NUM_LINES, 4, number of input lines
MUX_LINES, 8, number of one-hot mux selector outputs (>=2)
WORD_WIDTH, 1, samples packed per line per output word (>=1)
SYNC_STAGES, 2, synchroniser flops per input line (>=2)
DWELL_WIDTH, 16, width of the dwell register

Ports:
sysclk  in  1  system clock, all logic rising-edge
reset_n  in  1  asynchronous active-low reset
enable  in  1  sampling enable
smp_strobe  in  1  single-cycle sample pulse, sysclk domain
line_in  in  NUM_LINES  raw asynchronous line inputs
data_out  out  NUM_LINES*WORD_WIDTH  packed word; line k occupies bits [k*WORD_WIDTH +: WORD_WIDTH]
data_valid  out  1  data_out holds an unconsumed word
data_ready  in  1  consumer accepts the word
overflow  out  1  sticky: a word was overwritten before it was consumed
overflow_clr  in  1  clears overflow
mux_run  in  1  scanner run request
dwell  in  DWELL_WIDTH  cycles per mux position minus one
mux_out  out  MUX_LINES  one-hot selector
scan_wrap  out  1  one-cycle pulse when the scanner index wraps to 0
prbs_sel  in  1  test source select; used only with the optional feature

Behaviour:
- Reset (asynchronous, reset_n=0): data_out=0, data_valid=0, overflow=0, mux_out=0, scan_wrap=0. Synchronisers, shift registers and bit counter clear to 0. Scanner enters IDLE with index 0.
- Synchronisation: each line_in bit passes through SYNC_STAGES flops. A change on line_in is visible to the sampler SYNC_STAGES cycles later.
- Sampling: occurs on a cycle where enable=1 and smp_strobe=1.
  - Each line's synchronised bit shifts into that line's shift register at the LSB; older samples move toward the MSB.
  - The bit counter increments on each sample.
- Word completion: a sample taken with bit counter = WORD_WIDTH-1 completes a word.
  - The complete word, including the new bit, loads into data_out on that edge. data_valid=1 from the next cycle.
  - Bit counter returns to 0.
  - Strobe-to-valid latency is 1 cycle.
- enable=0: bit counter and shift registers clear to 0 and the partial word is discarded. data_out, data_valid and overflow are unaffected.
- Handshake: data_valid=1 and data_ready=1 on the same edge is a transfer. data_valid drops the next cycle unless a new word completes on that same edge.
  - Completion and transfer on the same edge: new word loads, data_valid stays 1, overflow unchanged.
  - Completion while data_valid=1 and data_ready=0: new word overwrites data_out, data_valid stays 1, overflow set to 1.
  - overflow_clr=1 clears overflow. If a set condition occurs on the same edge, set wins.
- Scanner FSM:
  - IDLE: mux_out=0, index=0, dwell counter=0. Leaves for SCAN when mux_run=1.
  - SCAN: mux_out=one-hot(index). The dwell counter increments each cycle.
  - When dwell counter == dwell, the counter clears and index advances. Index wraps from MUX_LINES-1 to 0, and scan_wrap pulses for 1 cycle on that wrap.
  - dwell=0 advances the index every cycle.
  - dwell is sampled live. If it is lowered below the current count, the counter runs to wrap of its width before matching; software changes dwell only in IDLE.
  - mux_run=0 in SCAN returns to IDLE on the next edge: mux_out=0, index=0.
- Reset asserted mid-word or mid-scan: all state returns to reset values immediately; no partial word is emitted.

Optional Feature:
- Macro: LINE_FRONTEND_PRBS_EN.
- When defined:
  - A 7-bit LFSR (x^7+x^6+1, seed 7'h7F, reset value 7'h7F) advances on every sampling event.
  - When prbs_sel=1, line k samples LFSR bit (k mod 7) instead of its synchronised input.
  - The LFSR advances regardless of prbs_sel.
- When undefined: no LFSR is built and prbs_sel is ignored. The port remains so the board-level wiring is identical in both builds.

Test Plan:
- WORD_WIDTH=1, line_in=4'b1010 held 5 cycles, one smp_strobe with enable=1 -> data_out=4'b1010, data_valid=1 exactly 1 cycle after the strobe.
- WORD_WIDTH=4, NUM_LINES=1, line_in sequence 1,0,1,1 on 4 strobes -> data_out=4'b1011, data_valid rises only after the 4th strobe.
- Two words complete with data_ready=0 -> data_out holds the second word, overflow=1. Pulse overflow_clr -> overflow=0. Completion coincident with data_ready=1 -> overflow stays 0.
- dwell=2, mux_run=1 -> mux_out sequence 0x01 (3 cycles), 0x02 (3 cycles), ..., 0x80. scan_wrap pulses when 0x80 returns to 0x01. Drop mux_run -> mux_out=0 next cycle.
- enable dropped after 2 of 4 strobes, then 4 more strobes -> one word containing only the last 4 samples.
- reset_n pulsed low mid-scan and mid-word -> all outputs 0 immediately. With LINE_FRONTEND_PRBS_EN and prbs_sel=1, the first word for line 0 equals 1.
